// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU opcodes and the forwarding bundle.
package cpu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RADDR_W = 5;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 4'b0000;
  localparam alu_op_t ALU_SUB  = 4'b0001;
  localparam alu_op_t ALU_AND  = 4'b0010;
  localparam alu_op_t ALU_OR   = 4'b0011;
  localparam alu_op_t ALU_XOR  = 4'b0100;
  localparam alu_op_t ALU_NOR  = 4'b0101;
  localparam alu_op_t ALU_SLT  = 4'b0110;
  localparam alu_op_t ALU_SLTU = 4'b0111;
  localparam alu_op_t ALU_SLL  = 4'b1000;
  localparam alu_op_t ALU_SRL  = 4'b1001;
  localparam alu_op_t ALU_LUI  = 4'b1010;
  localparam alu_op_t ALU_SRA  = 4'b1011;

  // One later-stage register write, as seen by the forwarding logic
  typedef struct packed {
    logic               we;
    logic [RADDR_W-1:0] rd;
    logic [XLEN-1:0]    data;
  } fwd_bus_t;

  // A producer matches a source when it writes that register and it is not x0
  function automatic logic fwd_hit(input fwd_bus_t f, input logic [RADDR_W-1:0] rs);
    return f.we && (f.rd == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode -> execute handshake bus, operand payload and MEM/WB forwarding inputs.
interface id_ex_stage_if;
  import cpu_pkg::*;

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [RADDR_W-1:0] in_rs1_addr;
  logic [RADDR_W-1:0] in_rs2_addr;
  logic [RADDR_W-1:0] in_rd_addr;
  logic [XLEN-1:0]    in_rs1_data;
  logic [XLEN-1:0]    in_rs2_data;
  logic [XLEN-1:0]    in_imm;
  logic               in_alu_src_imm;
  logic [3:0]         in_alu_control;
  logic               in_reg_write;

  logic               fwd_mem_we;
  logic [RADDR_W-1:0] fwd_mem_rd;
  logic [XLEN-1:0]    fwd_mem_data;
  logic               fwd_wb_we;
  logic [RADDR_W-1:0] fwd_wb_rd;
  logic [XLEN-1:0]    fwd_wb_data;

  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    alu_a;
  logic [XLEN-1:0]    alu_b;
  logic [3:0]         alu_control;
  logic [XLEN-1:0]    store_data;
  logic [RADDR_W-1:0] rd_addr;
  logic               reg_write;

  modport master (
    output flush, in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rs1_data,
           in_rs2_data, in_imm, in_alu_src_imm, in_alu_control, in_reg_write,
           fwd_mem_we, fwd_mem_rd, fwd_mem_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data,
           out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_control, store_data, rd_addr, reg_write
  );

  modport slave (
    input  flush, in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rs1_data,
           in_rs2_data, in_imm, in_alu_src_imm, in_alu_control, in_reg_write,
           fwd_mem_we, fwd_mem_rd, fwd_mem_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data,
           out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_control, store_data, rd_addr, reg_write
  );

endinterface

// File: rtl/id_ex_stage_fwd_sel.sv
// Operand source selector: MEM result, else WB result, else register-file data.
// Selection is active only when ID_EX_FWD_EN is defined; otherwise rf_data passes through.
module fwd_sel
  import cpu_pkg::*;
(
  input  logic [RADDR_W-1:0] rs,
  input  logic [XLEN-1:0]    rf_data,
  input  fwd_bus_t           mem,
  input  fwd_bus_t           wb,
  output logic [XLEN-1:0]    operand_c
);

`ifdef ID_EX_FWD_EN
  always_comb begin
    operand_c = rf_data;
    if (fwd_hit(mem, rs)) begin
      operand_c = mem.data;
    end else if (fwd_hit(wb, rs)) begin
      operand_c = wb.data;
    end
  end
`else
  logic unused_fwd_c;
  assign unused_fwd_c = ^{rs, mem, wb};
  assign operand_c    = rf_data;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush, and MEM/WB operand
// forwarding at capture and while stalled (forwarding built only with ID_EX_FWD_EN).
module id_ex_stage
  import cpu_pkg::*;
(
  input logic           clk,
  input logic           rst,
  id_ex_stage_if.slave  bus
);

  logic               vld_q;
  logic [XLEN-1:0]    alu_a_q;
  logic [XLEN-1:0]    alu_b_q;
  logic [XLEN-1:0]    store_q;
  logic [3:0]         ctrl_q;
  logic [RADDR_W-1:0] rd_q;
  logic [RADDR_W-1:0] rs1_q;
  logic [RADDR_W-1:0] rs2_q;
  logic               src_imm_q;
  logic               rw_q;

  logic               in_ready_c;
  logic               capture_c;
  logic               hold_c;
  logic               drain_c;
  fwd_bus_t           mem_c;
  fwd_bus_t           wb_c;
  logic [XLEN-1:0]    cap_a_c;
  logic [XLEN-1:0]    cap_b_c;
  logic [XLEN-1:0]    snp_a_c;
  logic [XLEN-1:0]    snp_b_c;

  assign in_ready_c = !bus.flush && (!vld_q || bus.out_ready);
  assign capture_c  = bus.in_valid && in_ready_c;
  assign hold_c     = vld_q && !bus.out_ready && !bus.flush;
  assign drain_c    = vld_q && bus.out_ready;

  assign mem_c = '{we: bus.fwd_mem_we, rd: bus.fwd_mem_rd, data: bus.fwd_mem_data};
  assign wb_c  = '{we: bus.fwd_wb_we,  rd: bus.fwd_wb_rd,  data: bus.fwd_wb_data};

  // Capture-time selection on the decode-side sources
  fwd_sel u_cap_a (.rs(bus.in_rs1_addr), .rf_data(bus.in_rs1_data), .mem(mem_c), .wb(wb_c), .operand_c(cap_a_c));
  fwd_sel u_cap_b (.rs(bus.in_rs2_addr), .rf_data(bus.in_rs2_data), .mem(mem_c), .wb(wb_c), .operand_c(cap_b_c));

  // Snoop on the held entry so a stalled operand picks up a producer that moved on
  fwd_sel u_snp_a (.rs(rs1_q), .rf_data(alu_a_q), .mem(mem_c), .wb(wb_c), .operand_c(snp_a_c));
  fwd_sel u_snp_b (.rs(rs2_q), .rf_data(store_q), .mem(mem_c), .wb(wb_c), .operand_c(snp_b_c));

  // alu_b is kept as its own flop so every output is a direct register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      store_q   <= '0;
      ctrl_q    <= ALU_ADD;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      src_imm_q <= 1'b0;
      rw_q      <= 1'b0;
    end else if (bus.flush) begin
      vld_q <= 1'b0;
      rw_q  <= 1'b0;
    end else if (capture_c) begin
      vld_q     <= 1'b1;
      alu_a_q   <= cap_a_c;
      alu_b_q   <= bus.in_alu_src_imm ? bus.in_imm : cap_b_c;
      store_q   <= cap_b_c;
      ctrl_q    <= bus.in_alu_control;
      rd_q      <= bus.in_rd_addr;
      rs1_q     <= bus.in_rs1_addr;
      rs2_q     <= bus.in_rs2_addr;
      src_imm_q <= bus.in_alu_src_imm;
      rw_q      <= bus.in_reg_write;
    end else if (hold_c) begin
      alu_a_q <= snp_a_c;
      store_q <= snp_b_c;
      if (!src_imm_q) begin
        alu_b_q <= snp_b_c;
      end
    end else if (drain_c) begin
      vld_q <= 1'b0;
      rw_q  <= 1'b0;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = vld_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_control = ctrl_q;
  assign bus.store_data  = store_q;
  assign bus.rd_addr     = rd_q;
  assign bus.reg_write   = rw_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow ID_EX_FWD_EN.
module tb_id_ex_stage;
  import cpu_pkg::*;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  id_ex_stage_if bus ();

  id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic src, input logic [3:0] ctrl, input logic rw);
    bus.in_valid       = 1'b1;
    bus.in_rs1_addr    = rs1;
    bus.in_rs2_addr    = rs2;
    bus.in_rd_addr     = rd;
    bus.in_rs1_data    = d1;
    bus.in_rs2_data    = d2;
    bus.in_imm         = imm;
    bus.in_alu_src_imm = src;
    bus.in_alu_control = ctrl;
    bus.in_reg_write   = rw;
  endtask

  task automatic set_fwd(input logic mwe, input logic [4:0] mrd, input logic [31:0] mdata,
                         input logic wwe, input logic [4:0] wrd, input logic [31:0] wdata);
    bus.fwd_mem_we   = mwe;
    bus.fwd_mem_rd   = mrd;
    bus.fwd_mem_data = mdata;
    bus.fwd_wb_we    = wwe;
    bus.fwd_wb_rd    = wrd;
    bus.fwd_wb_data  = wdata;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    bus.in_valid = 1'b0;
    set_fwd(0, 0, 0, 0, 0, 0);
    #3;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.alu_a !== 32'h0) begin errors++; $display("FAIL reset_alu_a: got %h expected 0", bus.alu_a); end
    checks++; if (bus.alu_control !== 4'b0000) begin errors++; $display("FAIL reset_alu_control: got %b expected 0000", bus.alu_control); end
    checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write: got %b expected 0", bus.reg_write); end
    @(negedge clk);
    rst = 1'b0;
    // Hold an entry, then assert reset between edges
    drive(5'd1, 5'd2, 5'd3, 32'hA5, 32'h5A, 32'h0, 1'b0, 4'b0001, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.alu_a !== 32'hA5) begin errors++; $display("FAIL pre_reset_alu_a: got %h expected a5", bus.alu_a); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.alu_a !== 32'h0) begin errors++; $display("FAIL async_reset_alu_a: got %h expected 0", bus.alu_a); end
    checks++; if (bus.alu_b !== 32'h0) begin errors++; $display("FAIL async_reset_alu_b: got %h expected 0", bus.alu_b); end
    checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL async_reset_reg_write: got %b expected 0", bus.reg_write); end
    checks++; if (bus.rd_addr !== 5'd0) begin errors++; $display("FAIL async_reset_rd: got %0d expected 0", bus.rd_addr); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fwd_capture();
    bus.out_ready = 1'b1;
    set_fwd(1, 5'd3, 32'h10, 1, 5'd3, 32'h20);
    drive(5'd3, 5'd0, 5'd4, 32'd5, 32'd9, 32'h0, 1'b0, 4'b0000, 1'b1);
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL cap_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.alu_a !== (FWD ? 32'h10 : 32'd5)) begin errors++; $display("FAIL cap_mem_prio: got %h expected %h", bus.alu_a, FWD ? 32'h10 : 32'd5); end
    checks++; if (bus.reg_write !== 1'b1) begin errors++; $display("FAIL cap_reg_write: got %b expected 1", bus.reg_write); end
    drive(5'd0, 5'd0, 5'd4, 32'd5, 32'd9, 32'h0, 1'b0, 4'b0000, 1'b1);
    tick();
    checks++; if (bus.alu_a !== 32'd5) begin errors++; $display("FAIL cap_x0_nomatch: got %h expected 5", bus.alu_a); end
    set_fwd(1, 5'd0, 32'h10, 1, 5'd0, 32'h20);
    drive(5'd0, 5'd0, 5'd4, 32'h77, 32'd9, 32'h0, 1'b0, 4'b0000, 1'b1);
    tick();
    checks++; if (bus.alu_a !== 32'h77) begin errors++; $display("FAIL cap_x0_never: got %h expected 77", bus.alu_a); end
    set_fwd(0, 5'd3, 32'h10, 1, 5'd3, 32'h20);
    drive(5'd3, 5'd3, 5'd4, 32'd5, 32'd6, 32'h0, 1'b0, 4'b0000, 1'b1);
    tick();
    checks++; if (bus.alu_a !== (FWD ? 32'h20 : 32'd5)) begin errors++; $display("FAIL cap_wb_a: got %h expected %h", bus.alu_a, FWD ? 32'h20 : 32'd5); end
    checks++; if (bus.alu_b !== (FWD ? 32'h20 : 32'd6)) begin errors++; $display("FAIL cap_wb_b: got %h expected %h", bus.alu_b, FWD ? 32'h20 : 32'd6); end
    checks++; if (bus.store_data !== (FWD ? 32'h20 : 32'd6)) begin errors++; $display("FAIL cap_wb_store: got %h expected %h", bus.store_data, FWD ? 32'h20 : 32'd6); end
    set_fwd(0, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL cap_drain: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_snoop();
    bus.out_ready = 1'b0;
    drive(5'd1, 5'd7, 5'd5, 32'h11, 32'h22, 32'h0, 1'b0, 4'b0001, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.alu_b !== 32'h22) begin errors++; $display("FAIL snoop_cap_b: got %h expected 22", bus.alu_b); end
    set_fwd(0, 0, 0, 1, 5'd7, 32'hDEAD);
    tick();
    checks++; if (bus.store_data !== (FWD ? 32'hDEAD : 32'h22)) begin errors++; $display("FAIL snoop_wb_store: got %h expected %h", bus.store_data, FWD ? 32'hDEAD : 32'h22); end
    checks++; if (bus.alu_b !== (FWD ? 32'hDEAD : 32'h22)) begin errors++; $display("FAIL snoop_wb_b: got %h expected %h", bus.alu_b, FWD ? 32'hDEAD : 32'h22); end
    checks++; if (bus.alu_a !== 32'h11) begin errors++; $display("FAIL snoop_a_kept: got %h expected 11", bus.alu_a); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL snoop_held: got %b expected 1", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL snoop_in_ready: got %b expected 0", bus.in_ready); end
    set_fwd(1, 5'd7, 32'hBEEF, 1, 5'd7, 32'hDEAD);
    tick();
    checks++; if (bus.store_data !== (FWD ? 32'hBEEF : 32'h22)) begin errors++; $display("FAIL snoop_mem_prio: got %h expected %h", bus.store_data, FWD ? 32'hBEEF : 32'h22); end
    set_fwd(0, 0, 0, 0, 0, 0);
    drive(5'd2, 5'd3, 5'd20, 32'h1, 32'h2, 32'h0, 1'b0, 4'b0000, 1'b1);
    tick();
    checks++; if (bus.rd_addr !== 5'd5) begin errors++; $display("FAIL stall_no_capture: got %0d expected 5", bus.rd_addr); end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL snoop_drain_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL snoop_drain_rw: got %b expected 0", bus.reg_write); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(5'd1, 5'd2, 5'(i + 1), 32'(i * 256), 32'h0, 32'h0, 1'b0, 4'b0000, 1'b1);
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, bus.in_ready); end
      @(posedge clk);
      #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.rd_addr !== 5'(i + 1) || bus.alu_a !== 32'(i * 256))
        begin errors++; $display("FAIL b2b_entry[%0d]: got v=%b rd=%0d a=%h expected v=1 rd=%0d a=%h", i, bus.out_valid, bus.rd_addr, bus.alu_a, i + 1, 32'(i * 256)); end
    end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(5'd1, 5'd2, 5'd9, 32'h3, 32'h4, 32'h0, 1'b0, 4'b0000, 1'b1);
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %b expected 1", bus.out_valid); end
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(5'd1, 5'd2, 5'd12, 32'h5, 32'h6, 32'h0, 1'b0, 4'b0000, 1'b1);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", bus.in_ready); end
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL flush_reg_write: got %b expected 0", bus.reg_write); end
    checks++; if (bus.rd_addr === 5'd12) begin errors++; $display("FAIL flush_captured: got rd %0d expected not 12", bus.rd_addr); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_stays_empty: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_imm();
    bus.out_ready = 1'b1;
    drive(5'd4, 5'd2, 5'd6, 32'h99, 32'h1234, 32'hFFFFFFFC, 1'b1, 4'b0110, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.alu_b !== 32'hFFFFFFFC) begin errors++; $display("FAIL imm_alu_b: got %h expected fffffffc", bus.alu_b); end
    checks++; if (bus.alu_control !== 4'b0110) begin errors++; $display("FAIL imm_alu_control: got %b expected 0110", bus.alu_control); end
    checks++; if (bus.store_data !== 32'h1234) begin errors++; $display("FAIL imm_store_data: got %h expected 1234", bus.store_data); end
    checks++; if (bus.alu_a !== 32'h99) begin errors++; $display("FAIL imm_alu_a: got %h expected 99", bus.alu_a); end
    tick();
  endtask

  initial begin
    test_reset();
    test_fwd_capture();
    test_snoop();
    test_back_to_back();
    test_flush();
    test_imm();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
